// File: rtl/bullet_manager.sv
// Per-frame bullet engine for the battle screen: moves, spawns and collision-checks a small
// pool of bullet slots, and serves the slot picked by the renderer's index.
module bullet_manager #(
  parameter int unsigned NUM_SLOTS    = 3,
  parameter int unsigned AREA_MAX     = 200,
  parameter int unsigned SPEED        = 2,
  parameter int unsigned HIT_DIST     = 16,
  parameter int unsigned SPAWN_PERIOD = 32,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        vsync,
  input  logic [2:0]  index,
  input  logic [15:0] playerPos,
  output logic [15:0] bulletPos,
  output logic [1:0]  bulletColor,
  output logic [2:0]  renderl,
  output logic        isRender,
  output logic        hit
);

  localparam int unsigned CntW    = $clog2(SPAWN_PERIOD + 1);
  localparam int unsigned RenderN = (NUM_SLOTS < 3) ? NUM_SLOTS : 3;

  typedef enum logic [1:0] {StIdle, StMove, StSpawn, StCheck} state_e;

  state_e                      state_q, state_d;
  logic [2:0]                  idx_q, idx_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic                        spawn_q, spawn_d;
  logic [15:0]                 lfsr_q, lfsr_d;
  logic                        vs_q;
  logic [NUM_SLOTS-1:0]        act_q, act_d;
  logic [NUM_SLOTS-1:0][7:0]   x_q, x_d, y_q, y_d;
  logic [NUM_SLOTS-1:0][1:0]   dir_q, dir_d;
  logic [NUM_SLOTS-1:0]        col_q, col_d;
  logic                        hit_d;

  logic       tick;
  logic [8:0] mv;
  logic [7:0] sp_p, px, py, dx, dy;
  logic       found;
  logic [15:0] sel_pos;
  logic [1:0]  sel_col;
  logic [2:0]  render_d;

  assign px = playerPos[15:8];
  assign py = playerPos[7:0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    spawn_d = spawn_q;
    lfsr_d  = lfsr_q;
    act_d   = act_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    col_d   = col_q;
    hit_d   = 1'b0;
    tick    = vsync & ~vs_q;
    mv      = '0;
    dx      = '0;
    dy      = '0;
    found   = 1'b0;
    sp_p    = lfsr_q[15:8];
    if (sp_p > 8'(AREA_MAX)) sp_p = sp_p - 8'(AREA_MAX);

    if (!enable) begin
      act_d   = '0;
      state_d = StIdle;
      idx_d   = '0;
      cnt_d   = '0;
      spawn_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (tick) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            if (cnt_q == CntW'(SPAWN_PERIOD - 1)) begin
              cnt_d   = '0;
              spawn_d = 1'b1;
            end else begin
              cnt_d   = cnt_q + CntW'(1);
              spawn_d = 1'b0;
            end
            idx_d   = '0;
            state_d = StMove;
          end
        end
        StMove: begin
          for (int k = 0; k < NUM_SLOTS; k++) begin
            if (idx_q == 3'(k) && act_q[k]) begin
              case (dir_q[k])
                2'd0:    mv = {1'b0, y_q[k]} + 9'(SPEED);
                2'd1:    mv = {1'b0, y_q[k]} - 9'(SPEED);
                2'd2:    mv = {1'b0, x_q[k]} + 9'(SPEED);
                default: mv = {1'b0, x_q[k]} - 9'(SPEED);
              endcase
              // Underflow wraps to a 9-bit value above AREA_MAX, so one compare covers both edges.
              if (mv > 9'(AREA_MAX)) act_d[k] = 1'b0;
              else if (dir_q[k][1])  x_d[k] = mv[7:0];
              else                   y_d[k] = mv[7:0];
            end
          end
          if (idx_q == 3'(NUM_SLOTS - 1)) state_d = StSpawn;
          else                            idx_d   = idx_q + 3'd1;
        end
        StSpawn: begin
          if (spawn_q) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
              if (!found && !act_q[k]) begin
                found    = 1'b1;
                act_d[k] = 1'b1;
                dir_d[k] = lfsr_q[1:0];
                col_d[k] = lfsr_q[2];
                case (lfsr_q[1:0])
                  2'd0:    begin x_d[k] = sp_p;           y_d[k] = 8'd0;           end
                  2'd1:    begin x_d[k] = sp_p;           y_d[k] = 8'(AREA_MAX);   end
                  2'd2:    begin x_d[k] = 8'd0;           y_d[k] = sp_p;           end
                  default: begin x_d[k] = 8'(AREA_MAX);   y_d[k] = sp_p;           end
                endcase
              end
            end
          end
          spawn_d = 1'b0;
          idx_d   = '0;
          state_d = StCheck;
        end
        StCheck: begin
          for (int k = 0; k < NUM_SLOTS; k++) begin
            if (idx_q == 3'(k) && act_q[k]) begin
              dx = (x_q[k] >= px) ? x_q[k] - px : px - x_q[k];
              dy = (y_q[k] >= py) ? y_q[k] - py : py - y_q[k];
              if (dx < 8'(HIT_DIST) && dy < 8'(HIT_DIST)) begin
                act_d[k] = 1'b0;
                hit_d    = 1'b1;
              end
            end
          end
          if (idx_q == 3'(NUM_SLOTS - 1)) begin
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    sel_pos  = '0;
    sel_col  = '0;
    render_d = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (index == 3'(k)) begin
        sel_pos = {x_q[k], y_q[k]};
        sel_col = {1'b0, col_q[k]};
      end
    end
    for (int k = 0; k < RenderN; k++) render_d[k] = act_d[k];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      spawn_q     <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      vs_q        <= 1'b0;
      act_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      dir_q       <= '0;
      col_q       <= '0;
      hit         <= 1'b0;
      renderl     <= '0;
      isRender    <= 1'b0;
      bulletPos   <= '0;
      bulletColor <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      spawn_q     <= spawn_d;
      lfsr_q      <= lfsr_d;
      vs_q        <= vsync;
      act_q       <= act_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      col_q       <= col_d;
      hit         <= hit_d;
      renderl     <= render_d;
      isRender    <= |render_d;
      bulletPos   <= sel_pos;
      bulletColor <= sel_col;
    end
  end

endmodule

// File: tb/tb_bullet_manager.sv
// Scoreboard bench for bullet_manager: a frame-level reference model queues expectations,
// and a single monitor compares them against the DUT when the driver signals a sample point.
module tb_bullet_manager;

  localparam int          NS   = 3;
  localparam int          AREA = 200;
  localparam int          SPD  = 2;
  localparam int          HD   = 16;
  localparam logic [15:0] FAR  = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset, enable, vsync;
  logic [2:0]  index;
  logic [15:0] playerPos;
  logic [15:0] bulletPos;
  logic [1:0]  bulletColor;
  logic [2:0]  renderl;
  logic        isRender;
  logic        hit;

  bullet_manager dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .vsync      (vsync),
    .index      (index),
    .playerPos  (playerPos),
    .bulletPos  (bulletPos),
    .bulletColor(bulletColor),
    .renderl    (renderl),
    .isRender   (isRender),
    .hit        (hit)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] renderl; int hits; } frame_exp_t;
  typedef struct { logic [2:0] idx; logic [15:0] pos; logic [1:0] col; } pos_exp_t;

  frame_exp_t fq[$];
  pos_exp_t   pq[$];
  event       sample_ev;
  bit         done = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         hit_total = 0;
  int         hit_seen = 0;

  // Reference model state
  logic [15:0] m_lfsr;
  int          m_cnt;
  logic        m_act [NS];
  int          m_x [NS];
  int          m_y [NS];
  int          m_dir [NS];
  int          m_col [NS];

  task automatic model_reset();
    m_lfsr = 16'hACE1;
    m_cnt  = 0;
    for (int k = 0; k < NS; k++) begin
      m_act[k] = 1'b0; m_x[k] = 0; m_y[k] = 0; m_dir[k] = 0; m_col[k] = 0;
    end
  endtask

  task automatic model_frame(input logic [15:0] p0, input logic [15:0] p1,
                             input logic [15:0] p2, output int hits);
    logic [15:0] pp [NS];
    bit spawn, placed;
    int nx, ny, p, dx, dy;
    pp[0] = p0; pp[1] = p1; pp[2] = p2;
    hits = 0;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    spawn = (m_cnt == 31);
    m_cnt = spawn ? 0 : m_cnt + 1;
    for (int k = 0; k < NS; k++) begin
      if (m_act[k]) begin
        nx = m_x[k]; ny = m_y[k];
        case (m_dir[k])
          0:       ny = ny + SPD;
          1:       ny = ny - SPD;
          2:       nx = nx + SPD;
          default: nx = nx - SPD;
        endcase
        if (nx < 0 || nx > AREA || ny < 0 || ny > AREA) m_act[k] = 1'b0;
        else begin m_x[k] = nx; m_y[k] = ny; end
      end
    end
    if (spawn) begin
      placed = 1'b0;
      for (int k = 0; k < NS; k++) begin
        if (!placed && !m_act[k]) begin
          placed = 1'b1;
          p = int'(m_lfsr[15:8]);
          if (p > AREA) p = p - AREA;
          m_act[k] = 1'b1;
          m_dir[k] = int'(m_lfsr[1:0]);
          m_col[k] = int'(m_lfsr[2]);
          case (m_dir[k])
            0:       begin m_x[k] = p;    m_y[k] = 0;    end
            1:       begin m_x[k] = p;    m_y[k] = AREA; end
            2:       begin m_x[k] = 0;    m_y[k] = p;    end
            default: begin m_x[k] = AREA; m_y[k] = p;    end
          endcase
        end
      end
    end
    for (int k = 0; k < NS; k++) begin
      if (m_act[k]) begin
        dx = m_x[k] - int'(pp[k][15:8]); if (dx < 0) dx = -dx;
        dy = m_y[k] - int'(pp[k][7:0]);  if (dy < 0) dy = -dy;
        if (dx < HD && dy < HD) begin m_act[k] = 1'b0; hits++; end
      end
    end
  endtask

  function automatic logic [2:0] m_render();
    return {m_act[2], m_act[1], m_act[0]};
  endfunction

  // Position slot k will hold after the next move step.
  function automatic logic [15:0] pred(input int k);
    int nx, ny;
    nx = m_x[k]; ny = m_y[k];
    case (m_dir[k])
      0:       ny = ny + SPD;
      1:       ny = ny - SPD;
      2:       nx = nx + SPD;
      default: nx = nx - SPD;
    endcase
    return {8'(nx), 8'(ny)};
  endfunction

  function automatic logic [15:0] offset_x(input logic [15:0] b, input int d);
    int bx;
    bx = int'(b[15:8]);
    bx = (bx + d <= 255) ? bx + d : bx - d;
    return {8'(bx), b[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (hit === 1'b1) hit_total++;
    end
  end

  // Monitor: consumes whatever expectations are queued at each sample point.
  initial begin
    frame_exp_t f;
    pos_exp_t   p;
    forever begin
      @(sample_ev);
      while (fq.size() > 0) begin
        f = fq.pop_front();
        chk("renderl", 32'(renderl), 32'(f.renderl));
        chk("isRender", 32'(isRender), 32'(|f.renderl));
        chk("hit_idle", 32'(hit), 32'd0);
        chk("hit_cycles", 32'(hit_total - hit_seen), 32'(f.hits));
        hit_seen = hit_total;
      end
      while (pq.size() > 0) begin
        p = pq.pop_front();
        chk($sformatf("bulletPos[%0d]", p.idx), 32'(bulletPos), 32'(p.pos));
        chk($sformatf("bulletColor[%0d]", p.idx), 32'(bulletColor), 32'(p.col));
      end
      if (done) begin
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic frame(input logic [15:0] p0, input logic [15:0] p1,
                       input logic [15:0] p2, input int hold);
    frame_exp_t f;
    int h;
    model_frame(p0, p1, p2, h);
    f.renderl = m_render();
    f.hits    = h;
    fq.push_back(f);
    vsync     = 1'b1;
    playerPos = p0;
    // Check cycles for slots 0/1/2 fall in the 5th/6th/7th cycle after the tick edge.
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 6) playerPos = p1;
      if (c == 7) playerPos = p2;
      if (c == 8) playerPos = FAR;
      if (c == hold) vsync = 1'b0;
    end
    vsync = 1'b0;
    #1 -> sample_ev;
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(FAR, FAR, FAR, 2);
  endtask

  task automatic rd(input logic [2:0] i, input logic [15:0] pos, input logic [1:0] col);
    pos_exp_t p;
    index = i;
    @(negedge clk);
    p.idx = i; p.pos = pos; p.col = col;
    pq.push_back(p);
    #1 -> sample_ev;
    #1;
  endtask

  task automatic rd_all();
    for (int k = 0; k < NS; k++)
      if (m_act[k]) rd(3'(k), {8'(m_x[k]), 8'(m_y[k])}, {1'b0, 1'(m_col[k])});
  endtask

  task automatic reset_checks();
    frame_exp_t f;
    pos_exp_t   p;
    f.renderl = 3'b000; f.hits = 0;
    fq.push_back(f);
    p.idx = index; p.pos = 16'h0000; p.col = 2'b00;
    pq.push_back(p);
    -> sample_ev;
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    vsync     = 1'b0;
    index     = 3'd0;
    playerPos = FAR;
    model_reset();
    #1 reset_checks();
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    #1;

    // First 31 frames spawn nothing; the 32nd fills slot 0.
    frames(31);
    frame(FAR, FAR, FAR, 2);
    rd_all();

    for (int f = 33; f <= 127; f++) begin
      frame(FAR, FAR, FAR, 2);
      if (f % 24 == 0 || f == 96) rd_all();
    end
    // All slots busy on this spawn frame: spawn dropped.
    frame(FAR, FAR, FAR, 2);
    rd_all();
    frames(3);
    // Slot 0 reaches the area edge and stays active, then leaves.
    frame(FAR, FAR, FAR, 2);
    rd_all();
    frame(FAR, FAR, FAR, 2);

    // Slot 1: dx exactly HIT_DIST misses, dx one less hits.
    begin
      logic [15:0] pp;
      pp = offset_x(pred(1), HD);
      frame(pp, pp, pp, 2);
      pp = offset_x(pred(1), HD - 1);
      frame(pp, pp, pp, 2);
      rd_all();
    end

    frames(25);
    rd_all();
    // Player moved between check cycles to overlap slots 0 and 2 separately.
    frame(pred(0), FAR, pred(2), 2);
    rd_all();

    // vsync held high for 10 clocks counts as one tick.
    frame(FAR, FAR, FAR, 10);
    frame(FAR, FAR, FAR, 2);
    rd(3'd5, 16'h0000, 2'b00);
    rd(3'd3, 16'h0000, 2'b00);

    // Enable dropped during MOVE aborts the frame.
    begin
      frame_exp_t f;
      int h;
      model_frame(FAR, FAR, FAR, h);
      for (int k = 0; k < NS; k++) m_act[k] = 1'b0;
      m_cnt = 0;
      f.renderl = 3'b000; f.hits = 0;
      fq.push_back(f);
      vsync = 1'b1;
      @(negedge clk);
      @(negedge clk);
      enable = 1'b0;
      vsync  = 1'b0;
      @(negedge clk);
      #1 -> sample_ev;
      #1 enable = 1'b1;
    end
    frames(5);

    // Asynchronous reset in the middle of a frame.
    vsync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 model_reset();
    reset_checks();
    @(negedge clk);
    reset = 1'b0;
    vsync = 1'b0;
    @(negedge clk);
    #1;
    frames(32);
    rd_all();

    done = 1'b1;
    -> sample_ev;
    #10;
    $display("FAIL monitor did not finish");
    $fatal(1);
  end

endmodule

// File: doc/bullet_manager.md
Name: bullet_manager

Overview:
- Upstream game-logic stage feeding the battle-screen renderer.
- Owns NUM_SLOTS bullet slots in play-area-local coordinates (0..AREA_MAX on each axis; the renderer adds the screen offset).
- Once per video frame: moves bullets, spawns new ones from an LFSR, and checks collision against the player heart.
- Presents the slot chosen by the renderer's index as a packed position/colour plus an active mask, and raises a hit pulse for HP logic.

Parameters:
NUM_SLOTS, 3, number of bullet slots (index width fixed at 3 bits, NUM_SLOTS<=8)
AREA_MAX, 200, max local coordinate on either axis
SPEED, 2, pixels moved per frame
HIT_DIST, 16, collision when |dx|<HIT_DIST and |dy|<HIT_DIST
SPAWN_PERIOD, 32, frames between spawn attempts
LFSR_SEED, 16'hACE1, LFSR reset value

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
enable  in  1  battle phase active
vsync  in  1  vsync from vga_sync (high during vertical retrace)
index  in  3  slot select from renderer
playerPos  in  16  {x[15:8], y[7:0]} local heart centre
bulletPos  out  16  {x,y} of selected slot
bulletColor  out  2  colour of selected slot: 0 white, 1 green
renderl  out  3  active mask, bit i = slot i active (bits >= NUM_SLOTS read 0)
isRender  out  1  OR of renderl
hit  out  1  one-cycle pulse per bullet colliding

Behaviour:
Reset values:
- All slots inactive; bulletPos=0, bulletColor=0, renderl=0, isRender=0, hit=0.
- LFSR=LFSR_SEED; frame counter=0; FSM=IDLE.

Frame tick:
- vsync is registered into vs_d; tick = vsync & ~vs_d (rising edge).
- A tick is taken only when enable=1 and FSM=IDLE; otherwise it is ignored (not queued).

FSM per tick:
- IDLE -> MOVE(i=0..NUM_SLOTS-1, one slot per clk) -> SPAWN -> CHECK(i=0..NUM_SLOTS-1) -> IDLE.
- Total 2*NUM_SLOTS+1 cycles after the tick cycle.

MOVE, active slot only, using 9-bit arithmetic:
- dir 0: y+=SPEED; dir 1: y-=SPEED; dir 2: x+=SPEED; dir 3: x-=SPEED.
- If the result is <0 or >AREA_MAX, the slot goes inactive. No wrap, no clamping.
- Exactly AREA_MAX stays active.

SPAWN:
- On the tick, the LFSR advances one step: Fibonacci, taps 16,14,13,11, shift left, feedback into bit 0.
- The frame counter increments on each taken tick.
- When the counter equals SPAWN_PERIOD-1, it clears and a spawn is attempted, using the LFSR value after the step.
- Target slot: lowest-numbered inactive slot. If none is free, the spawn is dropped; the counter still clears.
- p = lfsr[15:8]; if p > AREA_MAX then p = p - AREA_MAX.
- dir = lfsr[1:0]; colour = {1'b0, lfsr[2]}.
- Start position by dir:
  - dir 0: (p, 0)
  - dir 1: (p, AREA_MAX)
  - dir 2: (0, p)
  - dir 3: (AREA_MAX, p)
- A spawned bullet is not moved on its spawn frame, but is collision-checked in the same frame.

CHECK:
- Active slot i with |bx-px|<HIT_DIST and |by-py|<HIT_DIST goes inactive.
- hit=1 on the following cycle for one cycle.
- Several hits in one frame give separate pulses on distinct cycles.
- Distance exactly HIT_DIST is a miss.
- playerPos is sampled each CHECK cycle.

Outputs:
- bulletPos and bulletColor are registered, 1-cycle latency from index.
- index >= NUM_SLOTS gives bulletPos=0, bulletColor=0.
- renderl and isRender are registered from the slot-active bits.
- Outputs may change mid-frame during the FSM (this occurs in retrace, so it is acceptable).

enable=0:
- Next clk: all slots inactive, hit=0, FSM=IDLE, frame counter=0.
- LFSR holds.
- Applies mid-FSM as well; the sequence is aborted.

Reset mid-operation returns everything to reset values immediately.

Test Plan:
1. Reset, enable=1, 31 vsync pulses -> renderl=0. 32nd pulse -> LFSR steps from 16'hACE1 (32 steps total), one slot active in slot 0, start position/dir/colour match the reference-model LFSR; hit=0.
2. Preload via spawn a slot with dir 0 at y=198, SPEED=2 -> next frame y=200, still active. Following frame -> slot inactive, renderl bit 0 clears.
3. All 3 slots active, spawn frame reached -> spawn dropped, renderl=3'b111 unchanged. Frame counter restarts: next spawn attempt is 32 frames later.
4. playerPos set so bullet slot 1 has dx=15, dy=0 -> hit pulses exactly 1 cycle, renderl bit 1 clears. Repeat with dx=16 -> no hit.
5. Two slots overlapping the player in one frame -> two separate single-cycle hit pulses within the CHECK window; both slots cleared.
6. Deassert enable during MOVE -> next clk renderl=0, FSM IDLE. index=5 at any time -> bulletPos=0 one cycle later. vsync held high across 10 clocks -> only one tick taken.
